// File: rtl/debug_display_ctrl_if.sv
// Bundle between the datapath/controller and the board debug pins.
// Ports: SRC/TIME/DONE/Pkb toward the display, LED_B/DHEX/THEX/LED_D/LED_SEL back.
//   master : datapath/board side, drives SRC, TIME, DONE, Pkb
//   slave  : debug_display_ctrl, drives LED_B, DHEX, THEX, LED_D, LED_SEL
interface debug_display_ctrl_if #(
    parameter int DATA_W  = 10,
    parameter int NUM_SRC = 4,
    parameter int TIME_W  = 2
);
    localparam int NUM_DIGITS = (DATA_W + 3) / 4;
    localparam int SEL_W      = $clog2(NUM_SRC);

    logic [NUM_SRC*DATA_W-1:0] SRC;
    logic [TIME_W-1:0]         TIME;
    logic                      DONE;
    logic                      Pkb;
    logic [DATA_W-1:0]         LED_B;
    logic [7*NUM_DIGITS-1:0]   DHEX;
    logic [6:0]                THEX;
    logic                      LED_D;
    logic [SEL_W-1:0]          LED_SEL;

    modport master (
        output SRC, TIME, DONE, Pkb,
        input  LED_B, DHEX, THEX, LED_D, LED_SEL
    );

    modport slave (
        input  SRC, TIME, DONE, Pkb,
        output LED_B, DHEX, THEX, LED_D, LED_SEL
    );
endinterface

// File: rtl/debug_display_ctrl.sv
// Registered debug display: shows one of NUM_SRC channels on hex digits, with a debounced peek button.
// Ports: Clock, Resetn (async active-low), bus (debug_display_ctrl_if.slave: SRC, TIME, DONE, Pkb in;
//   LED_B, DHEX, THEX, LED_D, LED_SEL out). Optional macro DEBUG_DISPLAY_HOLD_EN adds a
//   hold register captured on the DONE rising edge and released by the next press.
module debug_display_ctrl #(
    parameter int DATA_W          = 10,
    parameter int NUM_SRC         = 4,
    parameter int TIME_W          = 2,
    parameter int DEBOUNCE_CYCLES = 16
) (
    input  logic                 Clock,
    input  logic                 Resetn,
    debug_display_ctrl_if.slave  bus
);
    localparam int NUM_DIGITS = (DATA_W + 3) / 4;
    localparam int PAD_W      = NUM_DIGITS * 4;
    localparam int SEL_W      = $clog2(NUM_SRC);
    localparam int CNT_W      = $clog2(DEBOUNCE_CYCLES);

    typedef logic [SEL_W-1:0] sel_t;
    typedef logic [CNT_W-1:0] cnt_t;

    localparam sel_t SEL_MAX = sel_t'(NUM_SRC - 1);
    localparam cnt_t CNT_MAX = cnt_t'(DEBOUNCE_CYCLES - 1);

    function automatic logic [6:0] seg7(input logic [3:0] n);
        logic [6:0] s;
        unique case (n)
            4'h0: s = 7'h40;
            4'h1: s = 7'h79;
            4'h2: s = 7'h24;
            4'h3: s = 7'h30;
            4'h4: s = 7'h19;
            4'h5: s = 7'h12;
            4'h6: s = 7'h02;
            4'h7: s = 7'h78;
            4'h8: s = 7'h00;
            4'h9: s = 7'h10;
            4'hA: s = 7'h08;
            4'hB: s = 7'h03;
            4'hC: s = 7'h46;
            4'hD: s = 7'h21;
            4'hE: s = 7'h06;
            4'hF: s = 7'h0E;
        endcase
        return s;
    endfunction

    // Channel unpacking
    logic [DATA_W-1:0] w_ch [NUM_SRC];

    for (genvar k = 0; k < NUM_SRC; k++) begin : g_ch
        assign w_ch[k] = bus.SRC[k*DATA_W +: DATA_W];
    end

    // Button synchroniser and debouncer; idle level is 1 (released)
    logic r_sync1;
    logic r_sync2;
    logic r_db_level;
    cnt_t r_db_cnt;
    logic w_mismatch;
    logic w_flip;
    logic w_press;

    assign w_mismatch = (r_sync2 != r_db_level);
    assign w_flip     = w_mismatch && (r_db_cnt == CNT_MAX);
    // Only the 1->0 flip is a press; the release flip is silent
    assign w_press    = w_flip && r_db_level;

    always_ff @(posedge Clock or negedge Resetn) begin
        if (!Resetn) begin
            r_sync1    <= 1'b1;
            r_sync2    <= 1'b1;
            r_db_level <= 1'b1;
            r_db_cnt   <= '0;
        end else begin
            r_sync1 <= bus.Pkb;
            r_sync2 <= r_sync1;
            if (w_flip) begin
                r_db_level <= ~r_db_level;
                r_db_cnt   <= '0;
            end else if (w_mismatch) begin
                r_db_cnt <= r_db_cnt + 1'b1;
            end else begin
                r_db_cnt <= '0;
            end
        end
    end

    // Channel select
    sel_t r_sel;

    always_ff @(posedge Clock or negedge Resetn) begin
        if (!Resetn) begin
            r_sel <= '0;
        end else if (w_press) begin
            r_sel <= (r_sel == SEL_MAX) ? '0 : r_sel + 1'b1;
        end
    end

    // Value to display
    logic [DATA_W-1:0] w_disp;

`ifdef DEBUG_DISPLAY_HOLD_EN
    typedef enum logic {
        ST_LIVE,
        ST_HOLD
    } state_t;

    state_t            r_state;
    state_t            w_state_nx;
    logic [DATA_W-1:0] r_hold;
    logic [DATA_W-1:0] w_hold_nx;
    logic              r_done_q;
    logic              w_done_rise;

    assign w_done_rise = bus.DONE && !r_done_q;

    always_ff @(posedge Clock or negedge Resetn) begin
        if (!Resetn) begin
            r_state  <= ST_LIVE;
            r_hold   <= '0;
            r_done_q <= 1'b0;
        end else begin
            r_state  <= w_state_nx;
            r_hold   <= w_hold_nx;
            r_done_q <= bus.DONE;
        end
    end

    // A DONE rise wins over a simultaneous press: capture uses the
    // pre-increment sel and the state stays HOLD.
    always_comb begin
        w_state_nx = r_state;
        w_hold_nx  = r_hold;
        unique case (r_state)
            ST_LIVE: begin
                if (w_done_rise) begin
                    w_state_nx = ST_HOLD;
                    w_hold_nx  = w_ch[r_sel];
                end
            end
            ST_HOLD: begin
                if (w_done_rise) begin
                    w_hold_nx = w_ch[r_sel];
                end else if (w_press) begin
                    w_state_nx = ST_LIVE;
                end
            end
        endcase
    end

    assign w_disp = (r_state == ST_HOLD) ? r_hold : w_ch[r_sel];
`else
    assign w_disp = w_ch[r_sel];
`endif

    // Segment encoding; top digit zero-extended
    logic [PAD_W-1:0]        w_disp_pad;
    logic [7*NUM_DIGITS-1:0] w_dhex_nx;
    logic [3:0]              w_time_nib;

    assign w_disp_pad = PAD_W'(w_disp);
    assign w_time_nib = 4'(bus.TIME);

    for (genvar i = 0; i < NUM_DIGITS; i++) begin : g_dig
        assign w_dhex_nx[7*i +: 7] = seg7(w_disp_pad[4*i +: 4]);
    end

    // Output registers
    logic [7*NUM_DIGITS-1:0] r_dhex;
    logic [6:0]              r_thex;
    logic                    r_led_d;
    logic [DATA_W-1:0]       r_led_b;

    always_ff @(posedge Clock or negedge Resetn) begin
        if (!Resetn) begin
            r_dhex  <= {NUM_DIGITS{7'h7F}};
            r_thex  <= 7'h7F;
            r_led_d <= 1'b1;
            r_led_b <= '0;
        end else begin
            r_dhex  <= w_dhex_nx;
            r_thex  <= seg7(w_time_nib);
            r_led_d <= ~bus.DONE;
            r_led_b <= w_ch[0];
        end
    end

    assign bus.DHEX    = r_dhex;
    assign bus.THEX    = r_thex;
    assign bus.LED_D   = r_led_d;
    assign bus.LED_B   = r_led_b;
    assign bus.LED_SEL = r_sel;
endmodule

// File: tb/tb_debug_display_ctrl.sv
// Directed bench for debug_display_ctrl (DATA_W=10, NUM_SRC=4, DEBOUNCE_CYCLES=4).
// Hold checks follow DEBUG_DISPLAY_HOLD_EN when it is defined.
module tb_debug_display_ctrl;
    logic Clock;
    logic Resetn;
    int   total;
    int   bad;

    debug_display_ctrl_if #(
        .DATA_W  (10),
        .NUM_SRC (4),
        .TIME_W  (2)
    ) bus ();

    debug_display_ctrl #(
        .DATA_W          (10),
        .NUM_SRC         (4),
        .TIME_W          (2),
        .DEBOUNCE_CYCLES (4)
    ) dut (
        .Clock  (Clock),
        .Resetn (Resetn),
        .bus    (bus)
    );

    initial Clock = 1'b0;
    always #5 Clock = ~Clock;

    task automatic tick();
        @(posedge Clock);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic set_ch(input int k, input logic [9:0] v);
        bus.SRC[k*10 +: 10] = v;
    endtask

    logic [1:0]  exp_sel  [4];
    logic [20:0] exp_dhex [4];

    initial begin
        total = 0;
        bad   = 0;
        exp_sel  = '{2'd2, 2'd3, 2'd0, 2'd1};
        exp_dhex = '{{7'h40, 7'h46, 7'h30},
                     {7'h30, 7'h06, 7'h78},
                     {7'h24, 7'h08, 7'h12},
                     {7'h79, 7'h12, 7'h12}};

        Resetn   = 1'b0;
        bus.Pkb  = 1'b1;
        bus.SRC  = '0;
        bus.TIME = '0;
        bus.DONE = 1'b0;
        repeat (2) tick();
        chk("rst_dhex", 32'(bus.DHEX), 32'h1FFFFF);
        chk("rst_thex", 32'(bus.THEX), 32'h7F);
        chk("rst_led_d", 32'(bus.LED_D), 32'h1);
        chk("rst_sel", 32'(bus.LED_SEL), 32'h0);
        chk("rst_led_b", 32'(bus.LED_B), 32'h0);

        Resetn = 1'b1;
        set_ch(0, 10'h2A5);
        set_ch(1, 10'h155);
        set_ch(2, 10'h0C3);
        set_ch(3, 10'h3E7);
        bus.TIME = 2'd3;
        tick();
        chk("ch0_dhex", 32'(bus.DHEX), 32'({7'h24, 7'h08, 7'h12}));
        chk("ch0_led_b", 32'(bus.LED_B), 32'h2A5);
        chk("thex3", 32'(bus.THEX), 32'h30);
        chk("led_d_idle", 32'(bus.LED_D), 32'h1);
        chk("sel_idle", 32'(bus.LED_SEL), 32'h0);

        // 3-clock glitch: too short to be accepted
        bus.Pkb = 1'b0;
        repeat (3) tick();
        bus.Pkb = 1'b1;
        repeat (8) tick();
        chk("glitch_sel", 32'(bus.LED_SEL), 32'h0);

        // Held press: one step after 2+4 clocks, nothing more
        bus.Pkb = 1'b0;
        repeat (5) tick();
        chk("press_t5", 32'(bus.LED_SEL), 32'h0);
        tick();
        chk("press_t6", 32'(bus.LED_SEL), 32'h1);
        chk("dhex_lag", 32'(bus.DHEX), 32'({7'h24, 7'h08, 7'h12}));
        tick();
        chk("dhex_ch1", 32'(bus.DHEX), 32'({7'h79, 7'h12, 7'h12}));
        repeat (13) tick();
        chk("held_sel", 32'(bus.LED_SEL), 32'h1);
        bus.Pkb = 1'b1;
        repeat (10) tick();
        chk("release_sel", 32'(bus.LED_SEL), 32'h1);

        // Four presses, wrapping through 3 -> 0
        for (int i = 0; i < 4; i++) begin
            bus.Pkb = 1'b0;
            repeat (6) tick();
            chk($sformatf("step%0d_sel", i), 32'(bus.LED_SEL), 32'(exp_sel[i]));
            tick();
            chk($sformatf("step%0d_dhex", i), 32'(bus.DHEX), 32'(exp_dhex[i]));
            bus.Pkb = 1'b1;
            repeat (8) tick();
        end

        // Live tracking and LED_B independent of sel
        set_ch(1, 10'h0AB);
        tick();
        chk("live_ch1", 32'(bus.DHEX), 32'({7'h40, 7'h08, 7'h03}));
        set_ch(0, 10'h1F0);
        tick();
        chk("led_b_new", 32'(bus.LED_B), 32'h1F0);
        chk("dhex_keep", 32'(bus.DHEX), 32'({7'h40, 7'h08, 7'h03}));

        // DONE indicator and hold
        set_ch(1, 10'h155);
        tick();
        chk("ch1_155", 32'(bus.DHEX), 32'({7'h79, 7'h12, 7'h12}));
        bus.DONE = 1'b1;
        chk("led_d_pre", 32'(bus.LED_D), 32'h1);
        tick();
        chk("led_d_on", 32'(bus.LED_D), 32'h0);
        set_ch(1, 10'h3FF);
        tick();
        tick();
`ifdef DEBUG_DISPLAY_HOLD_EN
        chk("hold_dhex", 32'(bus.DHEX), 32'({7'h79, 7'h12, 7'h12}));
`else
        chk("live_3ff", 32'(bus.DHEX), 32'({7'h30, 7'h0E, 7'h0E}));
`endif
        bus.DONE = 1'b0;
        tick();
        chk("led_d_off", 32'(bus.LED_D), 32'h1);
        bus.Pkb = 1'b0;
        repeat (6) tick();
        chk("rel_sel", 32'(bus.LED_SEL), 32'h2);
        tick();
        chk("rel_ch2", 32'(bus.DHEX), 32'({7'h40, 7'h46, 7'h30}));
        bus.Pkb = 1'b1;
        repeat (8) tick();

        // Async reset in the middle of a debounce
        bus.Pkb = 1'b0;
        repeat (3) tick();
        #2;
        Resetn = 1'b0;
        #1;
        chk("arst_dhex", 32'(bus.DHEX), 32'h1FFFFF);
        chk("arst_thex", 32'(bus.THEX), 32'h7F);
        chk("arst_led_d", 32'(bus.LED_D), 32'h1);
        chk("arst_sel", 32'(bus.LED_SEL), 32'h0);
        chk("arst_led_b", 32'(bus.LED_B), 32'h0);
        bus.Pkb = 1'b1;
        tick();
        Resetn = 1'b1;
        repeat (8) tick();
        chk("post_sel", 32'(bus.LED_SEL), 32'h0);
        chk("post_dhex", 32'(bus.DHEX), 32'({7'h79, 7'h0E, 7'h40}));
        chk("post_led_b", 32'(bus.LED_B), 32'h1F0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
